// File: rtl/file_batch_sequencer.sv
// file_batch_sequencer: walks the inclusive file-index range [first_idx, last_idx].
// For each index it issues a one-cycle start pulse and waits for a rising edge on
// the processing top's finish level. It ends with a done pulse and the count of
// completed files.
// Optional build macro FBS_TIMEOUT_EN adds a per-file watchdog. When it expires, the
// sticky error flag is set and the batch ends early.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for go; range latched and counters reset on accept
// PULSE | one cycle that produces the registered start pulse
// WAIT  | waiting for a finish rising edge (or watchdog expiry)
// NEXT  | compare against last index, then advance or finish
// DONE  | one cycle that produces the registered done pulse
module file_batch_sequencer #(
    parameter int IDX_W       = 10,
    parameter int CNT_W       = 11,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [IDX_W-1:0] first_idx,
    input  logic [IDX_W-1:0] last_idx,
    input  logic             finish,
    output logic             start,
    output logic [IDX_W-1:0] file_index,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] files_done,
    output logic             error
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PULSE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_NEXT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [IDX_W-1:0] file_index_q, file_index_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] files_done_q, files_done_d;
    logic             error_q, error_d;
    logic             start_q, start_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             finish_q, finish_d;
    logic             finish_rise;

`ifdef FBS_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wdog_q, wdog_d;
`endif

    assign finish_rise = finish & ~finish_q;

    // Next-state and datapath updates; pulses are decoded from the current state so
    // every output comes straight from a flop.
    always_comb begin
        state_d      = state_q;
        file_index_d = file_index_q;
        last_d       = last_q;
        files_done_d = files_done_q;
        error_d      = error_q;
        finish_d     = finish;
`ifdef FBS_TIMEOUT_EN
        wdog_d       = wdog_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    last_d       = last_idx;
                    file_index_d = first_idx;
                    files_done_d = '0;
                    error_d      = 1'b0;
                    state_d      = (first_idx > last_idx) ? S_DONE : S_PULSE;
                end
            end
            S_PULSE: begin
                state_d = S_WAIT;
`ifdef FBS_TIMEOUT_EN
                wdog_d  = '0;
`endif
            end
            S_WAIT: begin
                if (finish_rise) begin
                    files_done_d = files_done_q + 1'b1;
                    state_d      = S_NEXT;
                end
`ifdef FBS_TIMEOUT_EN
                else if (wdog_q == WD_W'(TIMEOUT_CYC - 1)) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
`endif
            end
            S_NEXT: begin
                // Compare before incrementing so last index 2^IDX_W-1 never wraps.
                if (file_index_q == last_q) begin
                    state_d = S_DONE;
                end else begin
                    file_index_d = file_index_q + 1'b1;
                    state_d      = S_PULSE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        start_d = (state_q == S_PULSE);
        done_d  = (state_q == S_DONE);
        busy_d  = (state_d != S_IDLE);
    end

    // State and output registers; reset abandons any batch immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            file_index_q <= '0;
            last_q       <= '0;
            files_done_q <= '0;
            error_q      <= 1'b0;
            start_q      <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            finish_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            file_index_q <= file_index_d;
            last_q       <= last_d;
            files_done_q <= files_done_d;
            error_q      <= error_d;
            start_q      <= start_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            finish_q     <= finish_d;
        end
    end

`ifdef FBS_TIMEOUT_EN
    // Per-file watchdog counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wdog_q <= '0;
        else      wdog_q <= wdog_d;
    end
`endif

    assign start      = start_q;
    assign file_index = file_index_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign files_done = files_done_q;
`ifdef FBS_TIMEOUT_EN
    assign error      = error_q;
`else
    assign error      = 1'b0;
`endif

endmodule

// File: tb/tb_file_batch_sequencer.sv
// Scoreboard bench for file_batch_sequencer: expected start/done events are queued
// by the stimulus, and a monitor pops and compares them as the DUT pulses.
module tb_file_batch_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       go = 1'b0;
    logic [9:0] first_idx = '0;
    logic [9:0] last_idx = '0;
    logic       finish;
    logic       start, busy, done, error;
    logic [9:0] file_index;
    logic [10:0] files_done;

    logic finish_man = 1'b0;
    logic finish_resp = 1'b0;
    bit   resp_en = 1'b0;
    int   resp_delay = 10;
    int   never_idx = -1;
    int   resp_cnt = 0;

    typedef struct {
        bit is_done;
        int val;
        int err;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    int total = 0;
    int bad = 0;

    assign finish = resp_en ? finish_resp : finish_man;

    file_batch_sequencer #(.IDX_W(10), .CNT_W(11), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst), .go(go), .first_idx(first_idx), .last_idx(last_idx),
        .finish(finish), .start(start), .file_index(file_index), .busy(busy),
        .done(done), .files_done(files_done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_start(input int idx);
        exp_t x;
        x.is_done = 1'b0; x.val = idx; x.err = 0;
        sb.push_back(x);
    endtask

    task automatic push_done(input int cnt, input int err);
        exp_t x;
        x.is_done = 1'b1; x.val = cnt; x.err = err;
        sb.push_back(x);
    endtask

    task automatic do_go(input int f, input int l);
        first_idx = f[9:0];
        last_idx  = l[9:0];
        go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
    endtask

    task automatic wait_done(input string name, input int lim);
        int n = 0;
        @(negedge clk);
        while (!done && n < lim) begin
            @(negedge clk);
            n++;
        end
        check(name, done, 1);
        @(negedge clk);
    endtask

    // Monitor: every start/done pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst && start) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_start: unexpected start idx=%0d, nothing queued", file_index);
            end else begin
                e = sb.pop_front();
                if (e.is_done || file_index != e.val[9:0]) begin
                    bad++;
                    $display("FAIL sb_start: got start idx=%0d expected kind_done=%0d val=%0d",
                             file_index, e.is_done, e.val);
                end
            end
        end
        if (rst && done) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_done: unexpected done files_done=%0d, nothing queued", files_done);
            end else begin
                e = sb.pop_front();
                if (!e.is_done || files_done != e.val[10:0] || error != e.err[0]) begin
                    bad++;
                    $display("FAIL sb_done: got files_done=%0d error=%0d expected kind_done=%0d val=%0d err=%0d",
                             files_done, error, e.is_done, e.val, e.err);
                end
            end
        end
    end

    // Processing-top model: drops finish on start and raises it resp_delay cycles later.
    always @(negedge clk) begin
        if (!rst) begin
            resp_cnt = 0;
        end else if (!resp_en) begin
            finish_resp = finish_man;
            resp_cnt = 0;
        end else if (start) begin
            finish_resp = 1'b0;
            resp_cnt = (int'(file_index) == never_idx) ? 0 : resp_delay;
        end else if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) finish_resp = 1'b1;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_start", start, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_files_done", files_done, 0);
        check("rst_file_index", file_index, 0);
        check("rst_error", error, 0);
        rst = 1'b1;
        @(negedge clk);

        // Batch 5..7 with latency and range-latch checks
        resp_en = 1'b1;
        resp_delay = 10;
        push_start(5); push_start(6); push_start(7); push_done(3, 0);
        do_go(5, 7);
        last_idx = 10'd9;
        @(negedge clk);
        check("lat_busy", busy, 1);
        check("lat_pre_start", start, 0);
        @(negedge clk);
        check("lat_start", start, 1);
        check("lat_index", file_index, 5);
        wait_done("b57_done", 200);
        check("b57_files_done", files_done, 3);
        check("b57_file_index", file_index, 7);
        check("b57_busy", busy, 0);
        check("b57_sb_empty", sb.size(), 0);

        // Single file at the top index, no wrap
        push_start(1023); push_done(1, 0);
        do_go(1023, 1023);
        wait_done("top_done", 100);
        check("top_file_index", file_index, 1023);
        check("top_files_done", files_done, 1);

        // Empty range: done two cycles after go, no start
        push_done(0, 0);
        do_go(9, 3);
        @(negedge clk);
        check("empty_lat1", done, 0);
        @(negedge clk);
        check("empty_done", done, 1);
        check("empty_files_done", files_done, 0);
        check("empty_file_index", file_index, 9);
        @(negedge clk);
        check("empty_sb_empty", sb.size(), 0);

        // finish held high from a prior job; go while busy ignored
        resp_en = 1'b0;
        finish_man = 1'b1;
        repeat (3) @(negedge clk);
        push_start(0); push_start(1); push_done(2, 0);
        do_go(0, 1);
        repeat (20) @(negedge clk);
        check("held_files_done", files_done, 0);
        check("held_file_index", file_index, 0);
        check("held_busy", busy, 1);
        do_go(7, 7);
        repeat (5) @(negedge clk);
        check("busy_go_index", file_index, 0);
        finish_man = 1'b0;
        repeat (2) @(negedge clk);
        finish_man = 1'b1;
        @(negedge clk);
        resp_en = 1'b1;
        wait_done("held_done", 200);
        check("held_final_files_done", files_done, 2);

        // Missing finish on file 2 of 0..4
        never_idx = 2;
        push_start(0); push_start(1); push_start(2);
`ifdef FBS_TIMEOUT_EN
        push_done(2, 1);
        do_go(0, 4);
        wait_done("to_done", 300);
        check("to_error", error, 1);
        check("to_files_done", files_done, 2);
        never_idx = -1;
        push_start(0); push_done(1, 0);
        do_go(0, 0);
        @(negedge clk);
        check("to_error_cleared", error, 0);
        wait_done("to_clear_done", 100);
`else
        do_go(0, 4);
        repeat (200) @(negedge clk);
        check("nto_busy", busy, 1);
        check("nto_error", error, 0);
        check("nto_files_done", files_done, 2);
        check("nto_file_index", file_index, 2);
        never_idx = -1;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
`endif
        check("pre_rst_sb_empty", sb.size(), 0);

        // Asynchronous reset in the middle of WAIT
        push_start(0);
        do_go(0, 3);
        repeat (5) @(negedge clk);
        check("midwait_busy", busy, 1);
        #2 rst = 1'b0;
        #1;
        check("arst_start", start, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_files_done", files_done, 0);
        check("arst_file_index", file_index, 0);
        check("arst_error", error, 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_busy", busy, 0);
        push_start(4); push_done(1, 0);
        do_go(4, 4);
        wait_done("post_rst_done", 100);
        check("post_rst_files_done", files_done, 1);
        check("final_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
